// File: rtl/cprv_pkg.sv
// Shared decode types for the cprv64g pipeline: opcodes, ALU/operand selects and the control bundle.
// Imported by both the decode and execute stages so the ctrl_t encoding stays in one place.
package cprv_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic       {SRC_B_RS2, SRC_B_IMM} src_b_e;

    typedef struct packed {
        alu_op_e    alu_op;
        src_a_e     src_a_sel;
        src_b_e     src_b_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       reg_write;
        logic       word_op;
    } ctrl_t;

    // alt is instr[30]; it selects SUB (register form only) and SRA.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt, input logic is_reg);
        case (funct3)
            3'b000:  alu_decode = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cprv_regfile.sv
// Integer register file, 2 async read ports and 1 write port; x0 reads as zero.
// Reads of the register being written this cycle see the incoming data (write-through).
module cprv_regfile #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr1,
    input  logic [AW-1:0]         raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        if (raddr1 == '0)                 rdata1 = '0;
        else if (we && raddr1 == waddr)   rdata1 = wdata;
        else                              rdata1 = mem[raddr1];
        if (raddr2 == '0)                 rdata2 = '0;
        else if (we && raddr2 == waddr)   rdata2 = wdata;
        else                              rdata2 = mem[raddr2];
    end

endmodule

// File: rtl/cprv_id_stage.sv
// RV64I decode: decode, immediate gen, regfile read and RAW/WAW scoreboard; 1-cycle registered output slot.
// Stalls fetch on hazards or when the held bundle is not taken; held outputs stay stable under backpressure.
module cprv_id_stage
    import cprv_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REGS    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_id_i,
    output logic                   ready_id_o,
    input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
    input  logic                   wb_we_i,
    input  logic [4:0]             wb_rd_i,
    input  logic [DATA_WIDTH-1:0]  wb_data_i,
    output logic                   valid_ex_o,
    input  logic                   ready_ex_i,
    output logic [DATA_WIDTH-1:0]  rs1_data_ex_o,
    output logic [DATA_WIDTH-1:0]  rs2_data_ex_o,
    output logic [DATA_WIDTH-1:0]  imm_ex_o,
    output logic [4:0]             rd_ex_o,
    output ctrl_t                  ctrl_ex_o,
    output logic                   illegal_ex_o
);

    logic [INSTR_WIDTH-1:0] ins;
    logic [4:0]             rs1, rs2, rd;
    logic [2:0]             funct3;
    logic                   uses_rs1, uses_rs2, writes_rd, illegal;
    imm_type_e              imm_type;
    ctrl_t                  ctrl;
    logic [DATA_WIDTH-1:0]  imm, rs1_data, rs2_data;
    logic [NUM_REGS-1:0]    busy, busy_eff, busy_nxt;
    logic                   cke, hazard, fire, wb_we;

    assign ins    = instr_data_id_i;
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];
    assign rd     = ins[11:7];
    assign funct3 = ins[14:12];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        imm_type  = IMM_R;
        ctrl      = '0;
        ctrl.mem_size = funct3;
        case (ins[6:0])
            OPC_LUI:   begin writes_rd = 1'b1; imm_type = IMM_U;
                             ctrl.src_a_sel = SRC_A_ZERO; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_AUIPC: begin writes_rd = 1'b1; imm_type = IMM_U;
                             ctrl.src_a_sel = SRC_A_PC; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_JAL:   begin writes_rd = 1'b1; imm_type = IMM_J; ctrl.jump = 1'b1;
                             ctrl.src_a_sel = SRC_A_PC; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_JALR:  begin writes_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I;
                             ctrl.jump = 1'b1; ctrl.jalr = 1'b1; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_B;
                             ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
            OPC_LOAD:  begin writes_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I;
                             ctrl.mem_read = 1'b1; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_STORE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_S;
                             ctrl.mem_write = 1'b1; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                writes_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I;
                ctrl.src_b_sel = SRC_B_IMM;
                ctrl.alu_op    = alu_decode(funct3, ins[30], 1'b0);
                ctrl.word_op   = ins[3];
            end
            OPC_OP, OPC_OP_32: begin
                writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                ctrl.alu_op  = alu_decode(funct3, ins[30], 1'b1);
                ctrl.word_op = ins[3];
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                // CSR forms read rs1 (register variants) and write rd; ECALL/EBREAK touch neither.
                imm_type  = IMM_I;
                writes_rd = (funct3 != 3'b000);
                uses_rs1  = (funct3 != 3'b000) && !funct3[2];
            end
            default: begin illegal = 1'b1; ctrl = '0; end
        endcase
        ctrl.reg_write = writes_rd && (rd != 5'd0);
    end

    always_comb begin
        case (imm_type)
            IMM_I:   imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{(DATA_WIDTH-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {{(DATA_WIDTH-32){ins[31]}}, ins[31:12], 12'b0};
            IMM_J:   imm = {{(DATA_WIDTH-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign wb_we = wb_we_i && !rst;

    cprv_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .we     (wb_we),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Same-cycle writeback releases its register before the hazard lookup; a new claim still wins.
    always_comb begin
        busy_eff = busy;
        if (wb_we_i) busy_eff[wb_rd_i] = 1'b0;
        busy_nxt = busy_eff;
        if (fire && writes_rd) busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign cke        = !valid_ex_o || ready_ex_i;
    assign hazard     = valid_id_i && ((busy_eff[rs1] && uses_rs1) || (busy_eff[rs2] && uses_rs2)
                                       || (busy_eff[rd] && writes_rd));
    assign ready_id_o = cke && !hazard;
    assign fire       = valid_id_i && ready_id_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_ex_o    <= 1'b0;
            rs1_data_ex_o <= '0;
            rs2_data_ex_o <= '0;
            imm_ex_o      <= '0;
            rd_ex_o       <= '0;
            ctrl_ex_o     <= '0;
            illegal_ex_o  <= 1'b0;
            busy          <= '0;
        end else begin
            busy <= busy_nxt;
            if (cke) begin
                valid_ex_o <= fire;
                if (fire) begin
                    rs1_data_ex_o <= rs1_data;
                    rs2_data_ex_o <= rs2_data;
                    imm_ex_o      <= imm;
                    rd_ex_o       <= ctrl.reg_write ? rd : 5'd0;
                    ctrl_ex_o     <= ctrl;
                    illegal_ex_o  <= illegal;
                end
            end
        end
    end

endmodule

// File: tb/tb_cprv_id_stage.sv
// Directed bench for cprv_id_stage: reset, operand read, RAW stall, backpressure, x0 and a decode vector table.
module tb_cprv_id_stage;
    import cprv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_id_i, ready_id_o;
    logic [31:0] instr_data_id_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [63:0] wb_data_i;
    logic        valid_ex_o, ready_ex_i;
    logic [63:0] rs1_data_ex_o, rs2_data_ex_o, imm_ex_o;
    logic [4:0]  rd_ex_o;
    ctrl_t       ctrl_ex_o;
    logic        illegal_ex_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cprv_id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .valid_id_i      (valid_id_i),
        .ready_id_o      (ready_id_o),
        .instr_data_id_i (instr_data_id_i),
        .wb_we_i         (wb_we_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .valid_ex_o      (valid_ex_o),
        .ready_ex_i      (ready_ex_i),
        .rs1_data_ex_o   (rs1_data_ex_o),
        .rs2_data_ex_o   (rs2_data_ex_o),
        .imm_ex_o        (imm_ex_o),
        .rd_ex_o         (rd_ex_o),
        .ctrl_ex_o       (ctrl_ex_o),
        .illegal_ex_o    (illegal_ex_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        ill;
        logic [5:0]  flags;   // {branch, jump, mem_read, mem_write, reg_write, word_op}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] flags_of(input ctrl_t c);
        return {c.branch, c.jump, c.mem_read, c.mem_write, c.reg_write, c.word_op};
    endfunction

    task automatic chk_held_add(input string tag);
        chk({tag, "_valid"}, 64'(valid_ex_o), 64'd1);
        chk({tag, "_rs1"}, rs1_data_ex_o, 64'h1235);
        chk({tag, "_rs2"}, rs2_data_ex_o, 64'h1235);
        chk({tag, "_rd"}, 64'(rd_ex_o), 64'd7);
        chk({tag, "_imm"}, imm_ex_o, 64'd0);
        chk({tag, "_flags"}, 64'(flags_of(ctrl_ex_o)), 64'b000010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [10];
        vecs[0] = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 1'b0, 6'b100000}; // beq x0,x0,-4
        vecs[1] = '{32'hFFFFFFFF, 64'd0,                   5'd0, 1'b1, 6'b000000}; // illegal
        vecs[2] = '{32'h000F8093, 64'd0,                   5'd1, 1'b0, 6'b000010}; // addi x1,x31,0
        vecs[3] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 5'd1, 1'b0, 6'b000010}; // lui x1,0x80000
        vecs[4] = '{32'hFE21AC23, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 1'b0, 6'b000100}; // sw x2,-8(x3)
        vecs[5] = '{32'h001000EF, 64'h800,                 5'd1, 1'b0, 6'b010010}; // jal x1,2048
        vecs[6] = '{32'h01003203, 64'd16,                  5'd4, 1'b0, 6'b001010}; // ld x4,16(x0)
        vecs[7] = '{32'hFFF0029B, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b0, 6'b000011}; // addiw x5,x0,-1
        vecs[8] = '{32'h00001197, 64'h1000,                5'd3, 1'b0, 6'b000010}; // auipc x3,1
        vecs[9] = '{32'h00008067, 64'd0,                   5'd0, 1'b0, 6'b010000}; // jalr x0,0(x1)

        rst = 1'b1; valid_id_i = 1'b1; instr_data_id_i = 32'h00128313;
        ready_ex_i = 1'b1; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        tick();
        tick();
        chk("rst_valid", 64'(valid_ex_o), 64'd0);
        chk("rst_rs1", rs1_data_ex_o, 64'd0);
        chk("rst_rs2", rs2_data_ex_o, 64'd0);
        chk("rst_imm", imm_ex_o, 64'd0);
        chk("rst_rd", 64'(rd_ex_o), 64'd0);
        chk("rst_ctrl", 64'(ctrl_ex_o), 64'd0);
        chk("rst_illegal", 64'(illegal_ex_o), 64'd0);
        rst = 1'b0; valid_id_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_id_o), 64'd1);

        // Operand read after writeback of x5.
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 64'h1234;
        tick();
        wb_we_i = 1'b0;
        valid_id_i = 1'b1; instr_data_id_i = 32'h00128313;
        #1;
        chk("addi_ready", 64'(ready_id_o), 64'd1);
        tick();
        instr_data_id_i = 32'h006303B3;  // add x7,x6,x6 depends on the addi
        #1;
        chk("addi_valid", 64'(valid_ex_o), 64'd1);
        chk("addi_rs1", rs1_data_ex_o, 64'h1234);
        chk("addi_imm", imm_ex_o, 64'd1);
        chk("addi_rd", 64'(rd_ex_o), 64'd6);
        chk("addi_regwrite", 64'(ctrl_ex_o.reg_write), 64'd1);
        chk("raw_ready0", 64'(ready_id_o), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("raw_stall_ready", 64'(ready_id_o), 64'd0);
            chk("raw_stall_bubble", 64'(valid_ex_o), 64'd0);
        end
        wb_we_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 64'h1235;
        #1;
        chk("raw_wb_ready", 64'(ready_id_o), 64'd1);
        tick();
        wb_we_i = 1'b0;

        // Backpressure with the add bundle held; lui x8,1 waits behind it.
        ready_ex_i = 1'b0;
        instr_data_id_i = 32'h00001437;
        #1;
        chk_held_add("add");
        chk("bp_ready0", 64'(ready_id_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_held_add("bp_hold");
            chk("bp_ready", 64'(ready_id_o), 64'd0);
        end
        ready_ex_i = 1'b1;
        #1;
        chk("bp_release_ready", 64'(ready_id_o), 64'd1);
        tick();
        valid_id_i = 1'b0;
        #1;
        chk("lui_valid", 64'(valid_ex_o), 64'd1);
        chk("lui_rd", 64'(rd_ex_o), 64'd8);
        chk("lui_imm", imm_ex_o, 64'h1000);
        tick();
        chk("drain_valid", 64'(valid_ex_o), 64'd0);
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 64'h77;
        tick();
        wb_rd_i = 5'd8;
        tick();

        // x0 ignores writes, including a same-cycle write.
        wb_rd_i = 5'd0; wb_data_i = 64'hDEAD;
        tick();
        valid_id_i = 1'b1; instr_data_id_i = 32'h00000033;
        #1;
        chk("x0_ready", 64'(ready_id_o), 64'd1);
        tick();
        valid_id_i = 1'b0; wb_we_i = 1'b0;
        #1;
        chk("x0_valid", 64'(valid_ex_o), 64'd1);
        chk("x0_rs1", rs1_data_ex_o, 64'd0);
        chk("x0_rs2", rs2_data_ex_o, 64'd0);

        // Decode table; any register claimed is released by a writeback before the next vector.
        foreach (vecs[i]) begin
            valid_id_i = 1'b1; instr_data_id_i = vecs[i].instr;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(ready_id_o), 64'd1);
            tick();
            valid_id_i = 1'b0;
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(valid_ex_o), 64'd1);
            chk($sformatf("vec%0d_imm", i), imm_ex_o, vecs[i].imm);
            chk($sformatf("vec%0d_rd", i), 64'(rd_ex_o), 64'(vecs[i].rd));
            chk($sformatf("vec%0d_illegal", i), 64'(illegal_ex_o), 64'(vecs[i].ill));
            chk($sformatf("vec%0d_flags", i), 64'(flags_of(ctrl_ex_o)), 64'(vecs[i].flags));
            if (vecs[i].ill) chk($sformatf("vec%0d_ctrl", i), 64'(ctrl_ex_o), 64'd0);
            if (vecs[i].flags[1]) begin
                wb_we_i = 1'b1; wb_rd_i = vecs[i].rd; wb_data_i = 64'(i);
                tick();
                wb_we_i = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
